// File: rtl/ddma_send_queue.sv
// ddma_send_queue: CPU-side descriptor queue feeding the ddma send port.
// Buffers DEPTH (address, flit count) descriptors and issues them one at a
// time over the ddma cmd/status handshake. It also counts received-packet IRQ
// pulses and holds a level IRQ toward the CPU until they are all acknowledged.
module ddma_send_queue #(
  parameter int ADDR_WIDTH  = 32,
  parameter int SIZE_WIDTH  = 16,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [ADDR_WIDTH-1:0]    push_addr,
  input  logic [SIZE_WIDTH-1:0]    push_nflits,
  output logic                     push_ready,
  input  logic                     irq_ack,
  output logic                     cmd_out,
  output logic [ADDR_WIDTH-1:0]    addr_out,
  output logic [SIZE_WIDTH-1:0]    nflits_out,
  input  logic                     status_in,
  input  logic                     irq_in,
  output logic                     irq,
  output logic [CNT_WIDTH-1:0]     pend_rx,
  output logic [CNT_WIDTH-1:0]     sent_cnt,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int QC_W  = PTR_W + 1;
  localparam int TMO_W = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  logic [ADDR_WIDTH-1:0] mem_addr_r   [DEPTH];
  logic [SIZE_WIDTH-1:0] mem_nflits_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [QC_W-1:0]       q_count_r;

  state_t                state_r;
  state_t                state_s;
  logic                  cmd_out_r;
  logic                  cmd_s;
  logic [TMO_W-1:0]      tmo_r;
  logic [TMO_W-1:0]      tmo_s;
  logic                  err_r;
  logic                  err_s;
  logic [CNT_WIDTH-1:0]  sent_cnt_r;
  logic [CNT_WIDTH-1:0]  pend_rx_r;

  logic                  push_s;
  logic                  pop_s;
  logic                  q_nonempty_s;

  assign q_nonempty_s = (q_count_r != {QC_W{1'b0}});
  assign push_ready   = (q_count_r < QC_W'(DEPTH));
  assign push_s       = push_valid & push_ready;

  // Descriptor storage; entries are only meaningful between rd and wr pointers.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_addr_r[wr_ptr_r]   <= push_addr;
      mem_nflits_r[wr_ptr_r] <= push_nflits;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      q_count_r <= {QC_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   q_count_r <= q_count_r + QC_W'(1);
        2'b01:   q_count_r <= q_count_r - QC_W'(1);
        default: q_count_r <= q_count_r;
      endcase
    end
  end

  // Issue FSM next-state: the head entry stays in the FIFO until ddma reports
  // completion, so a timed-out issue is simply retried from IDLE.
  always_comb begin
    state_s = state_r;
    cmd_s   = cmd_out_r;
    tmo_s   = tmo_r;
    err_s   = err_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (q_nonempty_s && !status_in) begin
          state_s = ST_ISSUE;
          cmd_s   = 1'b1;
          tmo_s   = {TMO_W{1'b0}};
        end else begin
          cmd_s   = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (status_in) begin
          // Drop cmd right away so ddma never sees it on return to config.
          cmd_s   = 1'b0;
          state_s = ST_WAIT_DONE;
        end else if (tmo_r == TMO_W'(ACK_TIMEOUT - 1)) begin
          cmd_s   = 1'b0;
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          cmd_s   = 1'b1;
          tmo_s   = tmo_r + TMO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        cmd_s = 1'b0;
        if (!status_in) begin
          pop_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cmd_s   = 1'b0;
      end
    endcase
  end

  // Issue FSM state, command, timeout, sticky error and completion counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cmd_out_r  <= 1'b0;
      tmo_r      <= {TMO_W{1'b0}};
      err_r      <= 1'b0;
      sent_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      cmd_out_r <= cmd_s;
      tmo_r     <= tmo_s;
      err_r     <= err_s;
      if (pop_s) begin
        sent_cnt_r <= sent_cnt_r + CNT_WIDTH'(1);
      end
    end
  end

  // Pending receive counter: simultaneous irq and ack cancel, saturates at max.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_rx_r <= {CNT_WIDTH{1'b0}};
    end else if (irq_in && irq_ack) begin
      pend_rx_r <= pend_rx_r;
    end else if (irq_in && (pend_rx_r != {CNT_WIDTH{1'b1}})) begin
      pend_rx_r <= pend_rx_r + CNT_WIDTH'(1);
    end else if (irq_ack && (pend_rx_r != {CNT_WIDTH{1'b0}})) begin
      pend_rx_r <= pend_rx_r - CNT_WIDTH'(1);
    end
  end

  assign cmd_out    = cmd_out_r;
  assign addr_out   = q_nonempty_s ? mem_addr_r[rd_ptr_r]   : {ADDR_WIDTH{1'b0}};
  assign nflits_out = q_nonempty_s ? mem_nflits_r[rd_ptr_r] : {SIZE_WIDTH{1'b0}};
  assign irq        = (pend_rx_r != {CNT_WIDTH{1'b0}});
  assign pend_rx    = pend_rx_r;
  assign sent_cnt   = sent_cnt_r;
  assign q_count    = q_count_r;
  assign err        = err_r;

endmodule
